// File: rtl/xor_word_sched_pkg.sv
// Shared types for the serial xor scheduler.
// FSM state encoding and requester index constants.
package xor_word_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/xor_word_sched_xor.sv
// Single-bit xor primitive shared by both requesters.
// Kept as its own cell so only one instance exists.
module Xor (
  input  logic a,
  input  logic b,
  output logic out
);

  assign out = a ^ b;

endmodule

// File: rtl/xor_word_sched.sv
// Round-robin scheduler sharing one 1-bit Xor between two requesters.
// Operands are xored serially, LSB first, one bit per clock.
module xor_word_sched
  import xor_word_sched_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             grant,
  output logic             busy
);

  state_t state, state_nx;

  logic [WIDTH-1:0] sa, sb, sr;
  logic [WIDTH-1:0] sr_nx;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             win;
  logic             any_req;
  logic             last_bit;
  logic             xbit;

  Xor u_xor (
    .a   (sa[0]),
    .b   (sb[0]),
    .out (xbit)
  );

  assign any_req  = req0 | req1;
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign sr_nx    = {xbit, sr[WIDTH-1:1]};

  // Contention goes to whoever did not win last time.
  always_comb begin
    win = REQ0;
    unique case (1'b1)
      req0 & req1:  win = ~last_grant;
      req1 & ~req0: win = REQ1;
      default:      win = REQ0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = SHIFT;
      SHIFT:   if (last_bit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    valid = (state == DONE);
    ack0  = (state == DONE) && (grant == REQ0);
    ack1  = (state == DONE) && (grant == REQ1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sa         <= '0;
      sb         <= '0;
      sr         <= '0;
      out        <= '0;
      cnt        <= '0;
      grant      <= REQ0;
      last_grant <= REQ1;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            sa         <= win ? a1 : a0;
            sb         <= win ? b1 : b0;
            grant      <= win;
            last_grant <= win;
            cnt        <= '0;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= sr_nx;
          cnt <= cnt + CNT_W'(1);
          if (last_bit) out <= sr_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_word_sched.sv
// Directed self-checking bench for xor_word_sched.
// Covers a 16-bit and a 4-bit instance.
module tb_xor_word_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic        ack0, ack1, valid, grant, busy;
  logic [15:0] out;

  logic        s_req0, s_req1;
  logic [3:0]  s_a0, s_b0, s_a1, s_b1;
  logic        s_ack0, s_ack1, s_valid, s_grant, s_busy;
  logic [3:0]  s_out;

  int compared   = 0;
  int mismatched = 0;
  logic valid_q  = 1'b0;

  always #5 clk = ~clk;

  xor_word_sched #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .out(out),
    .valid(valid), .grant(grant), .busy(busy)
  );

  xor_word_sched #(.WIDTH(4), .CNT_W(3)) dut4 (
    .clk(clk), .reset(reset),
    .req0(s_req0), .a0(s_a0), .b0(s_b0),
    .req1(s_req1), .a1(s_a1), .b1(s_b1),
    .ack0(s_ack0), .ack1(s_ack1), .out(s_out),
    .valid(s_valid), .grant(s_grant), .busy(s_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic sel,
                          input int exp_n,
                          input string tag);
    int n = 0;
    while (!(sel ? ack1 : ack0) && n < 64) begin
      tick();
      n++;
    end
    chk(tag, n, exp_n);
  endtask

  // Per-cycle protocol invariants on the 16-bit instance.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("valid_eq_ack", valid, ack0 | ack1);
      chk("ack_excl", ack0 & ack1, 1'b0);
      chk("single_pulse", valid & valid_q, 1'b0);
      if (valid) chk("valid_busy", busy, 1'b1);
    end
    valid_q <= valid;
  end

  initial begin
    int n;
    reset = 1'b1;
    req0 = 0; req1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    s_req0 = 0; s_req1 = 0;
    s_a0 = 0; s_b0 = 0; s_a1 = 0; s_b1 = 0;

    // 1: reset state, then a single req0
    tick(); tick();
    chk("rst_out", out, 16'h0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ack", {ack0, ack1}, 2'b00);
    chk("rst_grant", grant, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 0;
    req0 = 1; a0 = 16'hF0F0; b0 = 16'h0FF0;
    tick();
    chk("t1_busy", busy, 1'b1);
    wait_ack(1'b0, 16, "t1_lat");
    chk("t1_out", out, 16'hFF00);
    chk("t1_valid", valid, 1'b1);
    chk("t1_grant", grant, 1'b0);
    chk("t1_ack1", ack1, 1'b0);
    req0 = 0;
    tick();
    chk("t1_idle", busy, 1'b0);
    chk("t1_hold", out, 16'hFF00);
    tick();
    chk("t1_noop", busy, 1'b0);

    // 2: simultaneous first request after reset
    reset = 1; tick(); reset = 0;
    req0 = 1; req1 = 1;
    a0 = 16'hFFFF; b0 = 16'h0000;
    a1 = 16'h1234; b1 = 16'h1234;
    tick();
    wait_ack(1'b0, 16, "t2_lat0");
    chk("t2_out0", out, 16'hFFFF);
    chk("t2_g0", grant, 1'b0);
    req0 = 0;
    wait_ack(1'b1, 18, "t2_lat1");
    chk("t2_out1", out, 16'h0000);
    chk("t2_g1", grant, 1'b1);
    req1 = 0;
    tick(); tick();

    // 3: both held for four completions
    reset = 1; tick(); reset = 0;
    req0 = 1; req1 = 1;
    tick();
    wait_ack(1'b0, 16, "t3_lat_a");
    chk("t3_g_a", grant, 1'b0);
    chk("t3_o_a", out, 16'hFFFF);
    wait_ack(1'b1, 18, "t3_lat_b");
    chk("t3_g_b", grant, 1'b1);
    chk("t3_o_b", out, 16'h0000);
    wait_ack(1'b0, 18, "t3_lat_c");
    chk("t3_g_c", grant, 1'b0);
    wait_ack(1'b1, 18, "t3_lat_d");
    chk("t3_g_d", grant, 1'b1);
    req0 = 0; req1 = 0;
    tick();
    chk("t3_ack_gone", {ack0, ack1}, 2'b00);
    tick();

    // 4: reset in the middle of SHIFT
    req1 = 1; a1 = 16'hAAAA; b1 = 16'h5555;
    tick();
    for (int i = 0; i < 8; i++) tick();
    chk("t4_mid_busy", busy, 1'b1);
    reset = 1;
    tick();
    chk("t4_ack1", ack1, 1'b0);
    chk("t4_out", out, 16'h0000);
    chk("t4_busy", busy, 1'b0);
    reset = 0;
    tick();
    wait_ack(1'b1, 16, "t4_lat");
    chk("t4_out2", out, 16'hFFFF);
    chk("t4_g", grant, 1'b1);
    req1 = 0;
    tick(); tick();

    // 5: request dropped right after sampling
    req0 = 1; a0 = 16'h0001; b0 = 16'h0003;
    tick();
    req0 = 0; a0 = 16'hDEAD; b0 = 16'hBEEF;
    wait_ack(1'b0, 16, "t5_lat");
    chk("t5_out", out, 16'h0002);
    tick(); tick();
    chk("t5_noop", busy, 1'b0);
    chk("t5_hold", out, 16'h0002);

    // 6: narrow instance
    s_req0 = 1; s_a0 = 4'b1010; s_b0 = 4'b0110;
    tick();
    n = 0;
    while (!s_ack0 && n < 32) begin
      tick();
      n++;
    end
    chk("t6_lat", n, 4);
    chk("t6_out", s_out, 4'b1100);
    chk("t6_valid", s_valid, 1'b1);
    chk("t6_ack1", s_ack1, 1'b0);
    s_req0 = 0;
    tick();
    chk("t6_idle", s_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
